// File: rtl/i2c_passthru_pkg.sv
// Shared types and constants for the I2C passthrough bus arbiter.
package i2c_passthru_pkg;

  localparam int REC_CLOCKS  = 9;
  localparam int NUM_MASTERS = 2;

  typedef enum logic [3:0] {
    ARB_IDLE     = 4'd0,
    ARB_GRANT    = 4'd1,
    ARB_STUCK    = 4'd2,
    ARB_REC_LOW  = 4'd3,
    ARB_REC_HIGH = 4'd4,
    ARB_STOP_A   = 4'd5,
    ARB_STOP_B   = 4'd6,
    ARB_STOP_C   = 4'd7,
    ARB_REC_WAIT = 4'd8,
    ARB_FAILED   = 4'd9
  } arb_state_t;

  function automatic logic [NUM_MASTERS-1:0] gnt_vec(input logic idx);
    logic [NUM_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/i2c_passthru_bus_arb_if.sv
// Bundle of detector levels, bus levels, requests/grants and recovery drives.
interface i2c_passthru_bus_arb_if;
  import i2c_passthru_pkg::*;

  logic                   i_f_ref;
  logic                   i_idle;
  logic                   i_stuck;
  logic                   i_scl;
  logic                   i_sda;
  logic [NUM_MASTERS-1:0] i_req;
  logic [NUM_MASTERS-1:0] o_gnt;
  logic                   o_scl_oe;
  logic                   o_sda_oe;
  logic                   o_rec_active;
  logic                   o_rec_fail;

  // master is the arbiter side, slave is the surrounding passthrough logic
  modport master (
    input  i_f_ref, i_idle, i_stuck, i_scl, i_sda, i_req,
    output o_gnt, o_scl_oe, o_sda_oe, o_rec_active, o_rec_fail
  );

  modport slave (
    output i_f_ref, i_idle, i_stuck, i_scl, i_sda, i_req,
    input  o_gnt, o_scl_oe, o_sda_oe, o_rec_active, o_rec_fail
  );

endinterface

// File: rtl/i2c_passthru_tick_cnt.sv
// Saturating counter of f_ref ticks; done is high once term ticks were counted.
module i2c_passthru_tick_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tick,
  input  logic [WIDTH-1:0] term,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick && (cnt != term)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == term);

endmodule

// File: rtl/i2c_passthru_bus_arb.sv
// Two-master grant arbiter with stuck-bus handling for the I2C passthrough.
// Define I2C_PASSTHRU_BUS_RECOVERY_EN to build the 9-clock + STOP recovery sequencer.
module i2c_passthru_bus_arb
  import i2c_passthru_pkg::*;
#(
  parameter int F_REF_T_HALF       = 10,
  parameter int WIDTH_F_REF_T_HALF = 4,
  parameter int F_REF_GNT_TIMEOUT  = 200,
  parameter int WIDTH_F_REF_GNT    = 8,
  parameter int F_REF_REC_WAIT     = 100,
  parameter int REC_TRIES          = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  i2c_passthru_bus_arb_if.master bus
);

  localparam logic [3:0] S_IDLE     = ARB_IDLE;
  localparam logic [3:0] S_GRANT    = ARB_GRANT;
  localparam logic [3:0] S_STUCK    = ARB_STUCK;
  localparam logic [3:0] S_REC_LOW  = ARB_REC_LOW;
  localparam logic [3:0] S_REC_HIGH = ARB_REC_HIGH;
  localparam logic [3:0] S_STOP_A   = ARB_STOP_A;
  localparam logic [3:0] S_STOP_B   = ARB_STOP_B;
  localparam logic [3:0] S_STOP_C   = ARB_STOP_C;
  localparam logic [3:0] S_REC_WAIT = ARB_REC_WAIT;
  localparam logic [3:0] S_FAILED   = ARB_FAILED;

`ifdef I2C_PASSTHRU_BUS_RECOVERY_EN
  localparam logic [3:0] S_ON_STUCK = S_REC_LOW;
`else
  localparam logic [3:0] S_ON_STUCK = S_STUCK;
`endif

  logic [3:0]             state, state_nx;
  logic                   gidx, gidx_nx;
  logic                   rr, rr_nx;
  logic                   busy_seen, busy_nx;
  logic                   f_ref_q, tick, state_chg, gnt_done;
  logic [NUM_MASTERS-1:0] gnt_nx;

  // One shared rising-edge detector feeds every tick counter
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) f_ref_q <= 1'b0;
    else         f_ref_q <= bus.i_f_ref;
  end

  assign tick      = bus.i_f_ref & ~f_ref_q;
  assign state_chg = (state_nx != state);

  i2c_passthru_tick_cnt #(.WIDTH(WIDTH_F_REF_GNT)) u_gnt_cnt (
    .clk  (i_clk),
    .rst_n(i_rstn),
    .clr  (state_chg),
    .tick (tick),
    .term (WIDTH_F_REF_GNT'(F_REF_GNT_TIMEOUT)),
    .done (gnt_done)
  );

`ifdef I2C_PASSTHRU_BUS_RECOVERY_EN
  localparam int         WIDTH_REC_WAIT = $clog2(F_REF_REC_WAIT + 1);
  localparam logic [3:0] REC_LAST       = 4'(REC_CLOCKS);
  localparam logic [2:0] TRIES          = 3'(REC_TRIES);

  logic       phase_done, wait_done;
  logic [3:0] clk_cnt, clk_nx;
  logic [2:0] att, att_nx;
  logic       scl_oe_nx, sda_oe_nx, active_nx, fail_nx;

  i2c_passthru_tick_cnt #(.WIDTH(WIDTH_F_REF_T_HALF)) u_phase_cnt (
    .clk  (i_clk),
    .rst_n(i_rstn),
    .clr  (state_chg),
    .tick (tick),
    .term (WIDTH_F_REF_T_HALF'(F_REF_T_HALF)),
    .done (phase_done)
  );

  i2c_passthru_tick_cnt #(.WIDTH(WIDTH_REC_WAIT)) u_wait_cnt (
    .clk  (i_clk),
    .rst_n(i_rstn),
    .clr  (state_chg),
    .tick (tick),
    .term (WIDTH_REC_WAIT'(F_REF_REC_WAIT)),
    .done (wait_done)
  );

  logic unused_scl;
  assign unused_scl = bus.i_scl;
`else
  localparam int unused_cfg = F_REF_T_HALF + WIDTH_F_REF_T_HALF + F_REF_REC_WAIT + REC_TRIES;

  logic unused_bus;
  assign unused_bus = bus.i_scl ^ bus.i_sda;
`endif

  always_comb begin
    state_nx = state;
    gidx_nx  = gidx;
    rr_nx    = rr;
    busy_nx  = busy_seen;
`ifdef I2C_PASSTHRU_BUS_RECOVERY_EN
    clk_nx   = clk_cnt;
    att_nx   = att;
`endif
    case (state)
      S_IDLE: begin
        if (bus.i_stuck) begin
          state_nx = S_ON_STUCK;
        end else if (bus.i_idle && (bus.i_req != '0)) begin
          gidx_nx  = (bus.i_req == '1) ? rr : bus.i_req[1];
          rr_nx    = ~gidx_nx;
          busy_nx  = 1'b0;
          state_nx = S_GRANT;
        end
      end
      S_GRANT: begin
        if (bus.i_stuck) begin
          state_nx = S_ON_STUCK;
        end else begin
          if (!bus.i_idle) busy_nx = 1'b1;
          if ((busy_seen && bus.i_idle) || (!bus.i_req[gidx] && bus.i_idle) ||
              (gnt_done && !busy_seen)) begin
            state_nx = S_IDLE;
          end
        end
      end
`ifdef I2C_PASSTHRU_BUS_RECOVERY_EN
      S_REC_LOW:  if (phase_done) state_nx = S_REC_HIGH;
      S_REC_HIGH: begin
        if (phase_done) begin
          clk_nx   = (clk_cnt == REC_LAST) ? clk_cnt : clk_cnt + 4'd1;
          state_nx = (bus.i_sda || (clk_nx == REC_LAST)) ? S_STOP_A : S_REC_LOW;
        end
      end
      S_STOP_A:   if (phase_done) state_nx = S_STOP_B;
      S_STOP_B:   if (phase_done) state_nx = S_STOP_C;
      S_STOP_C:   if (phase_done) state_nx = S_REC_WAIT;
      S_REC_WAIT: begin
        if (bus.i_idle) begin
          att_nx   = '0;
          state_nx = S_IDLE;
        end else if (wait_done) begin
          att_nx   = (att == 3'd7) ? att : att + 3'd1;
          state_nx = (att_nx >= TRIES) ? S_FAILED : S_REC_LOW;
        end
      end
      S_FAILED:   state_nx = S_FAILED;
`else
      S_STUCK:    if (bus.i_idle) state_nx = S_IDLE;
`endif
      default:    state_nx = S_IDLE;
    endcase
`ifdef I2C_PASSTHRU_BUS_RECOVERY_EN
    // A fresh recovery attempt always starts counting clocks from zero
    if ((state_nx == S_REC_LOW) && (state != S_REC_HIGH)) clk_nx = '0;
`endif
  end

  always_comb begin
    gnt_nx = (state_nx == S_GRANT) ? gnt_vec(gidx_nx) : '0;
`ifdef I2C_PASSTHRU_BUS_RECOVERY_EN
    scl_oe_nx = (state_nx == S_REC_LOW) || (state_nx == S_STOP_A);
    sda_oe_nx = (state_nx == S_STOP_A) || (state_nx == S_STOP_B);
    active_nx = state_nx inside {[S_REC_LOW:S_REC_WAIT]};
    fail_nx   = (state_nx == S_FAILED);
`endif
  end

  // Outputs are registered from the next state so they change cleanly on the edge
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      gidx      <= 1'b0;
      rr        <= 1'b0;
      busy_seen <= 1'b0;
      bus.o_gnt <= '0;
    end else begin
      state     <= state_nx;
      gidx      <= gidx_nx;
      rr        <= rr_nx;
      busy_seen <= busy_nx;
      bus.o_gnt <= gnt_nx;
    end
  end

`ifdef I2C_PASSTHRU_BUS_RECOVERY_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      clk_cnt          <= '0;
      att              <= '0;
      bus.o_scl_oe     <= 1'b0;
      bus.o_sda_oe     <= 1'b0;
      bus.o_rec_active <= 1'b0;
      bus.o_rec_fail   <= 1'b0;
    end else begin
      clk_cnt          <= clk_nx;
      att              <= att_nx;
      bus.o_scl_oe     <= scl_oe_nx;
      bus.o_sda_oe     <= sda_oe_nx;
      bus.o_rec_active <= active_nx;
      bus.o_rec_fail   <= fail_nx;
    end
  end
`else
  assign bus.o_scl_oe     = 1'b0;
  assign bus.o_sda_oe     = 1'b0;
  assign bus.o_rec_active = 1'b0;
  assign bus.o_rec_fail   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_passthru_bus_arb.sv
// Directed self-checking bench for i2c_passthru_bus_arb (both recovery build options).
module tb_i2c_passthru_bus_arb;
  import i2c_passthru_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  int   div    = 0;
  int   tick_no = 0;

  always #5 clk = ~clk;

  i2c_passthru_bus_arb_if bus();

  i2c_passthru_bus_arb dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  // f_ref has a period of four clocks; tick_no counts its rising edges
  always @(negedge clk) begin
    div = div + 1;
    if (div % 4 == 2) begin
      bus.i_f_ref = 1'b1;
      tick_no     = tick_no + 1;
    end else if (div % 4 == 0) begin
      bus.i_f_ref = 1'b0;
    end
  end

  function automatic logic [5:0] obs();
    return {bus.o_rec_fail, bus.o_rec_active, bus.o_sda_oe, bus.o_scl_oe, bus.o_gnt};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_change(input int budget, output logic [5:0] val, output int ticks,
                             output bit ok);
    logic [5:0] start_v;
    int         t0;
    start_v = obs();
    t0      = tick_no;
    ok      = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (obs() !== start_v) begin
        ok = 1'b1;
        break;
      end
    end
    val   = obs();
    ticks = tick_no - t0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.i_idle = 1'b0; bus.i_stuck = 1'b0; bus.i_req = 2'b00;
    bus.i_scl = 1'b1;  bus.i_sda = 1'b1;
    step(2);
    checks++;
    if (obs() !== 6'b000000) begin
      fails++; $display("[TB] FAIL reset_outputs: got %b expected 000000", obs());
    end
    bus.i_idle = 1'b1; bus.i_req = 2'b11;
    step(2);
    checks++;
    if (bus.o_gnt !== 2'b00) begin
      fails++; $display("[TB] FAIL reset_hold_gnt: got %b expected 00", bus.o_gnt);
    end
    bus.i_req = 2'b00;
    rstn = 1'b1;
    step(1);
  endtask

  task automatic test_grant_on_idle();
    bus.i_idle = 1'b1; bus.i_req = 2'b01;
    step(1);
    checks++;
    if (bus.o_gnt !== 2'b01) begin
      fails++; $display("[TB] FAIL grant_latency: got %b expected 01", bus.o_gnt);
    end
    bus.i_idle = 1'b0;
    step(4);
    checks++;
    if (bus.o_gnt !== 2'b01) begin
      fails++; $display("[TB] FAIL grant_hold_busy: got %b expected 01", bus.o_gnt);
    end
    bus.i_idle = 1'b1;
    step(1);
    checks++;
    if (bus.o_gnt !== 2'b00) begin
      fails++; $display("[TB] FAIL grant_release_idle: got %b expected 00", bus.o_gnt);
    end
    bus.i_req = 2'b00;
    step(2);
  endtask

  task automatic release_after_busy();
    bus.i_idle = 1'b0;
    step(2);
    bus.i_idle = 1'b1;
    step(1);
  endtask

  task automatic test_contention();
    logic [1:0] exp_seq [3];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    bus.i_idle = 1'b1; bus.i_req = 2'b11;
    step(1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.o_gnt !== exp_seq[k]) begin
        fails++; $display("[TB] FAIL contention_grant%0d: got %b expected %b", k, bus.o_gnt, exp_seq[k]);
      end
      release_after_busy();
      checks++;
      if (bus.o_gnt !== 2'b00) begin
        fails++; $display("[TB] FAIL contention_release%0d: got %b expected 00", k, bus.o_gnt);
      end
      if (k == 2) bus.i_req = 2'b00;
      step(1);
    end
    step(1);
  endtask

  task automatic test_req_drop();
    bus.i_idle = 1'b1; bus.i_req = 2'b10;
    step(1);
    checks++;
    if (bus.o_gnt !== 2'b10) begin
      fails++; $display("[TB] FAIL single_req1: got %b expected 10", bus.o_gnt);
    end
    bus.i_req = 2'b00;
    step(1);
    checks++;
    if (bus.o_gnt !== 2'b00) begin
      fails++; $display("[TB] FAIL req_drop_release: got %b expected 00", bus.o_gnt);
    end
    bus.i_req = 2'b11;
    step(1);
    checks++;
    if (bus.o_gnt !== 2'b01) begin
      fails++; $display("[TB] FAIL rr_after_single: got %b expected 01", bus.o_gnt);
    end
    bus.i_req = 2'b00;
    step(2);
  endtask

  task automatic test_grant_timeout();
    logic [5:0] v;
    int         t;
    bit         ok;
    bus.i_idle = 1'b1; bus.i_req = 2'b01;
    step(1);
    wait_change(2000, v, t, ok);
    bus.i_req = 2'b00;
    checks++;
    if (!ok || v !== 6'b000000 || t < 199 || t > 201) begin
      fails++;
      $display("[TB] FAIL grant_timeout: got obs=%b ticks=%0d ok=%0d expected obs=000000 ticks=200+-1",
               v, t, ok);
    end
    step(2);
  endtask

  task automatic test_reset_midop();
    bus.i_idle = 1'b1; bus.i_req = 2'b01;
    step(1);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.o_gnt !== 2'b00) begin
      fails++; $display("[TB] FAIL async_reset_gnt: got %b expected 00", bus.o_gnt);
    end
    bus.i_req = 2'b00;
    step(2);
    rstn = 1'b1;
    step(1);
  endtask

`ifdef I2C_PASSTHRU_BUS_RECOVERY_EN
  // Runs SCL pulses and the STOP pattern, starting at REC_LOW entry and ending at STOP_C entry
  task automatic rec_sequence(input int exp_clocks, input int sda_release_pulse, input string tag);
    logic [5:0] v;
    logic [5:0] exp_v;
    int         t;
    bit         ok;
    for (int p = 1; p <= exp_clocks; p++) begin
      wait_change(200, v, t, ok);
      checks++;
      if (!ok || v !== 6'b010000 || t != 10) begin
        fails++; $display("[TB] FAIL %s_low%0d: got obs=%b ticks=%0d expected 010000 ticks=10", tag, p, v, t);
      end
      if (p == sda_release_pulse) bus.i_sda = 1'b1;
      exp_v = (p < exp_clocks) ? 6'b010100 : 6'b011100;
      wait_change(200, v, t, ok);
      checks++;
      if (!ok || v !== exp_v || t != 10) begin
        fails++; $display("[TB] FAIL %s_high%0d: got obs=%b ticks=%0d expected %b ticks=10", tag, p, v, t, exp_v);
      end
    end
    wait_change(200, v, t, ok);
    checks++;
    if (!ok || v !== 6'b011000 || t != 10) begin
      fails++; $display("[TB] FAIL %s_stop_a: got obs=%b ticks=%0d expected 011000 ticks=10", tag, v, t);
    end
    wait_change(200, v, t, ok);
    checks++;
    if (!ok || v !== 6'b010000 || t != 10) begin
      fails++; $display("[TB] FAIL %s_stop_b: got obs=%b ticks=%0d expected 010000 ticks=10", tag, v, t);
    end
  endtask

  task automatic test_stuck_recovery();
    logic [5:0] v;
    int         t;
    bit         ok;
    bus.i_idle = 1'b1; bus.i_req = 2'b01; bus.i_sda = 1'b0;
    step(1);
    bus.i_idle = 1'b0; bus.i_stuck = 1'b1; bus.i_req = 2'b00;
    step(1);
    bus.i_stuck = 1'b0;
    checks++;
    if (obs() !== 6'b010100) begin
      fails++; $display("[TB] FAIL stuck_preempt: got %b expected 010100", obs());
    end
    rec_sequence(9, 0, "full");
    bus.i_idle = 1'b1;
    wait_change(200, v, t, ok);
    checks++;
    if (!ok || v !== 6'b000000 || t != 10) begin
      fails++; $display("[TB] FAIL full_return_idle: got obs=%b ticks=%0d expected 000000 ticks=10", v, t);
    end
    step(2);
  endtask

  task automatic test_early_exit();
    logic [5:0] v;
    int         t;
    bit         ok;
    bus.i_idle = 1'b0; bus.i_sda = 1'b0; bus.i_stuck = 1'b1;
    step(1);
    bus.i_stuck = 1'b0;
    checks++;
    if (obs() !== 6'b010100) begin
      fails++; $display("[TB] FAIL idle_stuck_enter: got %b expected 010100", obs());
    end
    rec_sequence(3, 3, "early");
    bus.i_idle = 1'b1;
    wait_change(200, v, t, ok);
    checks++;
    if (!ok || v !== 6'b000000 || t != 10) begin
      fails++; $display("[TB] FAIL early_return_idle: got obs=%b ticks=%0d expected 000000 ticks=10", v, t);
    end
    step(2);
  endtask

  task automatic test_failure();
    logic [5:0] v;
    logic [5:0] exp_v;
    int         t;
    bit         ok;
    bus.i_idle = 1'b0; bus.i_sda = 1'b0; bus.i_stuck = 1'b1;
    step(1);
    bus.i_stuck = 1'b0;
    for (int a = 1; a <= 3; a++) begin
      rec_sequence(9, 0, "fail");
      exp_v = (a < 3) ? 6'b010100 : 6'b100000;
      wait_change(2000, v, t, ok);
      checks++;
      if (!ok || v !== exp_v || t != 110) begin
        fails++; $display("[TB] FAIL attempt%0d_wait: got obs=%b ticks=%0d expected %b ticks=110", a, v, t, exp_v);
      end
    end
    bus.i_idle = 1'b1; bus.i_req = 2'b01;
    step(4);
    checks++;
    if (obs() !== 6'b100000) begin
      fails++; $display("[TB] FAIL failed_sticky: got %b expected 100000", obs());
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (obs() !== 6'b000000) begin
      fails++; $display("[TB] FAIL fail_async_clear: got %b expected 000000", obs());
    end
    bus.i_req = 2'b00;
    step(2);
    rstn = 1'b1;
    step(1);
  endtask
`else
  task automatic test_stuck_no_recovery();
    bus.i_idle = 1'b1; bus.i_req = 2'b01;
    step(1);
    bus.i_stuck = 1'b1;
    step(1);
    checks++;
    if (obs() !== 6'b000000) begin
      fails++; $display("[TB] FAIL stuck_preempt: got %b expected 000000", obs());
    end
    bus.i_stuck = 1'b0; bus.i_idle = 1'b0;
    step(4);
    checks++;
    if (bus.o_gnt !== 2'b00) begin
      fails++; $display("[TB] FAIL stuck_hold: got %b expected 00", bus.o_gnt);
    end
    bus.i_idle = 1'b1;
    step(1);
    checks++;
    if (bus.o_gnt !== 2'b00) begin
      fails++; $display("[TB] FAIL stuck_exit_cycle: got %b expected 00", bus.o_gnt);
    end
    step(1);
    checks++;
    if (bus.o_gnt !== 2'b01) begin
      fails++; $display("[TB] FAIL stuck_regrant: got %b expected 01", bus.o_gnt);
    end
    bus.i_req = 2'b00;
    step(1);
    bus.i_req = 2'b01; bus.i_stuck = 1'b1;
    step(1);
    bus.i_stuck = 1'b0;
    checks++;
    if (bus.o_gnt !== 2'b00) begin
      fails++; $display("[TB] FAIL stuck_priority: got %b expected 00", bus.o_gnt);
    end
    step(2);
    checks++;
    if (bus.o_gnt !== 2'b01) begin
      fails++; $display("[TB] FAIL stuck_priority_regrant: got %b expected 01", bus.o_gnt);
    end
    bus.i_req = 2'b00;
    step(2);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_grant_on_idle();
    test_contention();
    test_req_drop();
    test_grant_timeout();
`ifdef I2C_PASSTHRU_BUS_RECOVERY_EN
    test_stuck_recovery();
    test_early_exit();
    test_failure();
`else
    test_stuck_no_recovery();
`endif
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
